console_line_scroller: RTL and testbench
========================================

Name: console_line_scroller

Overview:
- Parametrised successor to the PS/2 command-history tracker.
- Keeps LINES rows of COLS characters. The bottom row mirrors the live PS/2 line being typed; the rows above hold committed history.
- A commit pulse scrolls the history up by one row.
- On a start pulse, the block streams the visible window (VIS_COLS columns of every row) to the character-display writer as index/data pairs with a valid strobe, then pulses finish.

Parameters:
- LINES, 8, number of rows including the live bottom row (>=2).
- COLS, 32, characters per row (row pitch of the display address space).
- VIS_COLS, 12, columns per row actually streamed (1..COLS).
- CHAR_W, 8, bits per character.
- IDX_W, 8, width of char_index (>= clog2(LINES*COLS)).
- CURSOR_CHAR, 8'h5F, cursor glyph (used only with CURSOR_EN).

Ports:
- clock  in  1  system clock, all logic on its rising edge.
- reset_n  in  1  synchronous active-low reset.
- live_line  in  COLS*CHAR_W  current typed line; column 0 in the MSB byte.
- line_commit  in  1  one-cycle pulse: push live_line into history.
- start  in  1  one-cycle pulse: begin a scan-out frame.
- cursor_col  in  clog2(COLS)  cursor column in the live row (CURSOR_EN only).
- busy  out  1  high while scanning.
- char_valid  out  1  char_index/char_data valid this cycle.
- char_index  out  IDX_W  row*COLS + col.
- char_data  out  CHAR_W  character for that position.
- finish  out  1  one-cycle pulse when a frame completes.
- commit_overflow  out  1  sticky: a commit was dropped.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - All history rows set to 8'h00; FSM to IDLE.
  - busy, char_valid, finish and commit_overflow go to 0; char_index and char_data go to 0.
  - The pending-commit flag is cleared.
  - Reset mid-scan aborts the frame with no finish pulse.
- Storage:
  - Rows 0..LINES-2 are history registers.
  - Row LINES-1 is not stored; it reads live_line directly, so a scan shows its value at the moment each character is read.
- Commit, applied in IDLE:
  - Row r <= row r+1 for r = 0..LINES-3.
  - Row LINES-2 <= live_line.
  - Row 0 content is discarded.
- Commit during SCAN:
  - The first commit sets the pending flag; history is frozen for a consistent frame.
  - The pending commit is applied on the cycle the FSM returns to IDLE, using live_line captured when the commit arrived.
  - A second commit while pending is dropped and sets commit_overflow. Only reset clears commit_overflow.
- FSM states and transitions:
  - IDLE -> SCAN on start, with row=0, col=0.
  - SCAN: every cycle, register char_valid=1, char_index=row*COLS+col, char_data=row[row][col].
    - col increments; when col==VIS_COLS-1, col<=0 and row increments.
    - After emitting (LINES-1, VIS_COLS-1), go to DONE.
  - DONE: char_valid=0, finish=1 for exactly one cycle, then -> IDLE.
- Latency and handshake:
  - First char_valid appears in the cycle after start is sampled.
  - A frame is exactly LINES*VIS_COLS consecutive valid cycles; finish follows the last one directly.
  - busy is high in SCAN and DONE.
  - start is ignored in SCAN and DONE.
  - start and line_commit together in IDLE: the commit is applied and the scan starts in the same edge, so the frame shows post-commit history.
- Columns VIS_COLS..COLS-1 are never emitted; index gaps are intentional.
- Arithmetic:
  - char_index is computed as row*COLS+col, truncated to IDX_W.
  - The counters are sized clog2(LINES) and clog2(COLS).
  - No wrap beyond the last row; a new frame restarts at 0.

Optional Feature:
- Macro: CONSOLE_LINE_SCROLLER_CURSOR_EN.
- Defined:
  - When emitting row LINES-1 at col==cursor_col, char_data=CURSOR_CHAR instead of the live character.
  - If cursor_col >= VIS_COLS, nothing is substituted.
- Undefined:
  - The cursor_col port is absent and the live row is streamed unmodified.

Test Plan:
1. Reset, then start with defaults -> 96 valid cycles, indices 0..11, 32..43, …, 224..235; all data 8'h00; finish one cycle after index 235; busy low the cycle after finish.
2. live_line col0..2 = "ABC", commit, then start -> index 192..194 = 41/42/43; index 224..226 = "ABC" (live mirror); rows 0..5 all zero.
3. Seven commits of 8'h31..8'h37 in col0, then start -> index 0 = 31, 32 = 32, …, 192 = 37.
4. Start, commit "X" at scan cycle 10, commit "Y" at cycle 20 -> frame shows pre-commit history; after finish, row 6 col0 = "X"; commit_overflow=1.
5. Start during SCAN at cycle 50 -> ignored; exactly 96 valid cycles and a single finish. Reset_n low at cycle 40 -> char_valid=0 next cycle, no finish, history zeroed.
6. With CONSOLE_LINE_SCROLLER_CURSOR_EN and cursor_col=3 -> index 227 data = 8'h5F. With cursor_col=20 -> live data is unchanged.

Source files
------------

// File: rtl/console_line_scroller.sv
// rtl/console_line_scroller.sv - scrolling console history with windowed character scan-out
// Optional cursor overlay on the live row: define CONSOLE_LINE_SCROLLER_CURSOR_EN.
module console_line_scroller #(
  parameter int               LINES       = 8,
  parameter int               COLS        = 32,
  parameter int               VIS_COLS    = 12,
  parameter int               CHAR_W      = 8,
  parameter int               IDX_W       = 8,
  parameter logic [CHAR_W-1:0] CURSOR_CHAR = 8'h5F
) (
  input  logic                     i_clock,
  input  logic                     i_reset_n,
  input  logic [COLS*CHAR_W-1:0]   i_live_line,
  input  logic                     i_line_commit,
  input  logic                     i_start,
`ifdef CONSOLE_LINE_SCROLLER_CURSOR_EN
  input  logic [$clog2(COLS)-1:0]  i_cursor_col,
`endif
  output logic                     o_busy,
  output logic                     o_char_valid,
  output logic [IDX_W-1:0]         o_char_index,
  output logic [CHAR_W-1:0]        o_char_data,
  output logic                     o_finish,
  output logic                     o_commit_overflow
);

  localparam int ROW_W  = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int COL_W  = $clog2(COLS);
  localparam int LINE_W = COLS * CHAR_W;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t             r_state, w_state_next;
  logic [LINE_W-1:0]  r_hist [LINES-1];
  logic [LINE_W-1:0]  r_pend_line;
  logic               r_pending;
  logic [ROW_W-1:0]   r_row;
  logic [COL_W-1:0]   r_col;

  logic               w_do_shift;
  logic [LINE_W-1:0]  w_shift_line;
  logic [LINE_W-1:0]  w_view [LINES];
  logic               w_emit;
  logic [ROW_W-1:0]   w_emit_row, w_next_row;
  logic [COL_W-1:0]   w_emit_col, w_next_col;
  logic [LINE_W-1:0]  w_row_vec;
  logic [CHAR_W-1:0]  w_char;

  assign o_busy = (r_state != S_IDLE);

  // The first character is emitted on the start edge itself, so r_row/r_col hold the next position.
  always_comb begin
    w_state_next = r_state;
    w_do_shift   = 1'b0;
    w_shift_line = i_live_line;
    w_emit       = 1'b0;
    w_emit_row   = r_row;
    w_emit_col   = r_col;
    case (r_state)
      S_IDLE: begin
        w_do_shift = i_line_commit;
        if (i_start) begin
          w_emit       = 1'b1;
          w_emit_row   = '0;
          w_emit_col   = '0;
          w_state_next = S_SCAN;
        end
      end
      S_SCAN: begin
        w_emit = 1'b1;
        if (r_row == ROW_W'(LINES-1) && r_col == COL_W'(VIS_COLS-1))
          w_state_next = S_DONE;
      end
      S_DONE: begin
        w_state_next = S_IDLE;
        if (r_pending) begin
          w_do_shift   = 1'b1;
          w_shift_line = r_pend_line;
        end else begin
          w_do_shift = i_line_commit;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Post-commit view of all rows; feeds both the history update and same-edge scan reads.
  always_comb begin
    for (int r = 0; r < LINES-1; r++) w_view[r] = r_hist[r];
    w_view[LINES-1] = i_live_line;
    if (w_do_shift) begin
      for (int r = 0; r < LINES-2; r++) w_view[r] = r_hist[r+1];
      w_view[LINES-2] = w_shift_line;
    end
  end

  always_comb begin
    w_row_vec = w_view[LINES-1];
    for (int r = 0; r < LINES-1; r++)
      if (w_emit_row == ROW_W'(r)) w_row_vec = w_view[r];
    w_char = '0;
    for (int c = 0; c < COLS; c++)
      if (w_emit_col == COL_W'(c)) w_char = w_row_vec[(COLS-1-c)*CHAR_W +: CHAR_W];
`ifdef CONSOLE_LINE_SCROLLER_CURSOR_EN
    if (w_emit_row == ROW_W'(LINES-1) && w_emit_col == i_cursor_col &&
        int'(i_cursor_col) < VIS_COLS)
      w_char = CURSOR_CHAR;
`endif
    if (w_emit_col == COL_W'(VIS_COLS-1)) begin
      w_next_row = w_emit_row + 1'b1;
      w_next_col = '0;
    end else begin
      w_next_row = w_emit_row;
      w_next_col = w_emit_col + 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_state_next;
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      for (int r = 0; r < LINES-1; r++) r_hist[r] <= '0;
      r_pend_line       <= '0;
      r_pending         <= 1'b0;
      r_row             <= '0;
      r_col             <= '0;
      o_char_valid      <= 1'b0;
      o_char_index      <= '0;
      o_char_data       <= '0;
      o_finish          <= 1'b0;
      o_commit_overflow <= 1'b0;
    end else begin
      o_char_valid <= w_emit;
      o_finish     <= (r_state == S_DONE);
      if (w_emit) begin
        o_char_index <= IDX_W'(int'(w_emit_row) * COLS + int'(w_emit_col));
        o_char_data  <= w_char;
        r_row        <= w_next_row;
        r_col        <= w_next_col;
      end
      if (w_do_shift)
        for (int r = 0; r < LINES-1; r++) r_hist[r] <= w_view[r];
      // History stays frozen during a frame; one commit is deferred, further ones are lost.
      if (r_state == S_SCAN && i_line_commit) begin
        if (r_pending) begin
          o_commit_overflow <= 1'b1;
        end else begin
          r_pending   <= 1'b1;
          r_pend_line <= i_live_line;
        end
      end
      if (r_state == S_DONE && r_pending) begin
        r_pending <= 1'b0;
        if (i_line_commit) o_commit_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_console_line_scroller.sv
// tb/tb_console_line_scroller.sv - directed table-driven bench for console_line_scroller
module tb_console_line_scroller;
  localparam int LINES = 8, COLS = 32, VIS_COLS = 12, CHAR_W = 8, IDX_W = 8;
  localparam int NCH = LINES * VIS_COLS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset_n = 1'b0;
  logic                   line_commit = 1'b0;
  logic                   start = 1'b0;
  logic [COLS*CHAR_W-1:0] live_line = '0;
  logic                   busy, char_valid, finish, commit_overflow;
  logic [IDX_W-1:0]       char_index;
  logic [CHAR_W-1:0]      char_data;
`ifdef CONSOLE_LINE_SCROLLER_CURSOR_EN
  logic [4:0]             cursor_col = 5'd31;
`endif

  console_line_scroller dut (
    .i_clock(clk), .i_reset_n(reset_n), .i_live_line(live_line),
    .i_line_commit(line_commit), .i_start(start),
`ifdef CONSOLE_LINE_SCROLLER_CURSOR_EN
    .i_cursor_col(cursor_col),
`endif
    .o_busy(busy), .o_char_valid(char_valid), .o_char_index(char_index),
    .o_char_data(char_data), .o_finish(finish), .o_commit_overflow(commit_overflow)
  );

  typedef struct { int phase; int idx; logic [7:0] exp; } vec_t;
  vec_t vecs[$];

  int n_cmp = 0, n_fail = 0;
  logic [7:0] cap [256];
  int n_valid, n_finish, idx_err, gap_err, busy_err, finish_cyc, last_cyc, busy_after, valid_after_rst;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int exp_index(input int k);
    return (k / VIS_COLS) * COLS + (k % VIS_COLS);
  endfunction

  function automatic logic [COLS*CHAR_W-1:0] line_of(input logic [7:0] a, b, c, d);
    return {a, b, c, d, {((COLS-4)*CHAR_W){1'b0}}};
  endfunction

  // Pulses start (optionally with commit), then samples every negedge; cycle 0 is the
  // cycle right after the start edge. Mid-frame commit/start/reset events by cycle number.
  task automatic run_frame(input int c1, input logic [7:0] ch1, input int c2, input logic [7:0] ch2,
                           input int c_start, input int c_rst, input bit with_commit);
    for (int i = 0; i < 256; i++) cap[i] = 8'hEE;
    n_valid = 0; n_finish = 0; idx_err = 0; gap_err = 0; busy_err = 0;
    finish_cyc = -1; last_cyc = -1; busy_after = 1; valid_after_rst = 1;
    @(negedge clk); start = 1'b1; line_commit = with_commit;
    @(negedge clk); start = 1'b0; line_commit = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (char_valid) begin
        if (int'(char_index) != exp_index(n_valid)) idx_err++;
        if (cyc != n_valid) gap_err++;
        if (!busy) busy_err++;
        cap[char_index] = char_data;
        n_valid++;
        last_cyc = cyc;
      end
      if (finish) begin
        n_finish++;
        if (finish_cyc < 0) finish_cyc = cyc;
      end
      if (cyc == c_rst + 1) valid_after_rst = int'(char_valid);
      if (finish_cyc >= 0 && cyc == finish_cyc + 1) begin
        busy_after = int'(busy);
        break;
      end
      line_commit = 1'b0;
      if (cyc == c1) begin live_line = line_of(ch1, 0, 0, 0); line_commit = 1'b1; end
      if (cyc == c2) begin live_line = line_of(ch2, 0, 0, 0); line_commit = 1'b1; end
      start   = (cyc == c_start);
      reset_n = !(cyc == c_rst);
      @(negedge clk);
    end
    start = 1'b0; line_commit = 1'b0; reset_n = 1'b1;
  endtask

  task automatic check_frame(input string nm);
    check({nm, "_valid_count"}, n_valid, NCH);
    check({nm, "_finish_count"}, n_finish, 1);
    check({nm, "_finish_after_last"}, finish_cyc, last_cyc + 1);
    check({nm, "_index_seq_errors"}, idx_err, 0);
    check({nm, "_gap_errors"}, gap_err, 0);
    check({nm, "_busy_low_in_frame"}, busy_err, 0);
    check({nm, "_busy_after_finish"}, busy_after, 0);
  endtask

  task automatic check_phase(input int ph, input string nm);
    foreach (vecs[i])
      if (vecs[i].phase == ph)
        check($sformatf("%s_data_idx%0d", nm, vecs[i].idx), int'(cap[vecs[i].idx]), int'(vecs[i].exp));
  endtask

  initial begin
    vecs = '{
      '{1, 0, 8'h00}, '{1, 11, 8'h00}, '{1, 224, 8'h00}, '{1, 235, 8'h00},
      '{2, 192, 8'h41}, '{2, 193, 8'h42}, '{2, 194, 8'h43}, '{2, 195, 8'h00},
      '{2, 224, 8'h41}, '{2, 226, 8'h43}, '{2, 0, 8'h00}, '{2, 160, 8'h00},
      '{3, 0, 8'h31}, '{3, 32, 8'h32}, '{3, 64, 8'h33}, '{3, 96, 8'h34}, '{3, 128, 8'h35},
      '{3, 160, 8'h36}, '{3, 192, 8'h37}, '{3, 193, 8'h00}, '{3, 224, 8'h37},
      '{4, 0, 8'h31}, '{4, 192, 8'h37}, '{4, 224, 8'h59},
      '{5, 0, 8'h32}, '{5, 160, 8'h37}, '{5, 192, 8'h58}, '{5, 224, 8'h59},
      '{6, 0, 8'h00}, '{6, 192, 8'h00}, '{6, 224, 8'h5A},
      '{7, 192, 8'h51}, '{7, 160, 8'h00}, '{7, 224, 8'h51}
    };
`ifdef CONSOLE_LINE_SCROLLER_CURSOR_EN
    vecs.push_back('{8, 224, 8'h41}); vecs.push_back('{8, 226, 8'h43});
    vecs.push_back('{8, 227, 8'h5F}); vecs.push_back('{8, 228, 8'h00});
    vecs.push_back('{9, 226, 8'h43}); vecs.push_back('{9, 227, 8'h44});
`endif

    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(char_valid), 0);
    check("rst_finish", int'(finish), 0);
    check("rst_overflow", int'(commit_overflow), 0);
    check("rst_index", int'(char_index), 0);
    check("rst_data", int'(char_data), 0);
    reset_n = 1'b1;
    @(negedge clk);

    run_frame(-1, 0, -1, 0, -1, -1, 0);
    check_frame("t1"); check_phase(1, "t1");

    live_line = line_of(8'h41, 8'h42, 8'h43, 8'h00); line_commit = 1'b1;
    @(negedge clk); line_commit = 1'b0;
    run_frame(-1, 0, -1, 0, -1, -1, 0);
    check_frame("t2"); check_phase(2, "t2");

    for (int k = 1; k <= 7; k++) begin
      live_line = line_of(8'(8'h30 + k), 0, 0, 0); line_commit = 1'b1;
      @(negedge clk); line_commit = 1'b0;
    end
    run_frame(-1, 0, -1, 0, -1, -1, 0);
    check_frame("t3"); check_phase(3, "t3");

    run_frame(10, 8'h58, 20, 8'h59, -1, -1, 0);
    check_frame("t4"); check_phase(4, "t4");
    check("t4_overflow", int'(commit_overflow), 1);

    run_frame(-1, 0, -1, 0, 50, -1, 0);
    check_frame("t5"); check_phase(5, "t5");

    run_frame(-1, 0, -1, 0, -1, 40, 0);
    check("t5r_valid_count", n_valid, 41);
    check("t5r_valid_after_reset", valid_after_rst, 0);
    check("t5r_finish_count", n_finish, 0);
    check("t5r_overflow_cleared", int'(commit_overflow), 0);
    check("t5r_busy", int'(busy), 0);

    live_line = line_of(8'h5A, 0, 0, 0);
    run_frame(-1, 0, -1, 0, -1, -1, 0);
    check_frame("t6"); check_phase(6, "t6");

    live_line = line_of(8'h51, 0, 0, 0);
    run_frame(-1, 0, -1, 0, -1, -1, 1);
    check_frame("t7"); check_phase(7, "t7");

`ifdef CONSOLE_LINE_SCROLLER_CURSOR_EN
    live_line = line_of(8'h41, 8'h42, 8'h43, 8'h44);
    cursor_col = 5'd3;
    run_frame(-1, 0, -1, 0, -1, -1, 0);
    check_frame("t8"); check_phase(8, "t8");
    live_line = line_of(8'h41, 8'h42, 8'h43, 8'h44);
    cursor_col = 5'd20;
    run_frame(-1, 0, -1, 0, -1, -1, 0);
    check_frame("t9"); check_phase(9, "t9");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
